ch_frame_sequencer: RTL and testbench
=====================================

// Module: ch_frame_sequencer
// PURPOSE
// - Sequences an 8-channel x 16-bit sample bus into a single 16-bit word stream for the host FIFO.
// - Per sample strobe: snapshot all channels, emit channels 0..numch-1 one word each with a valid/ready handshake.
// - Drives a one-hot channel tag alongside each word.
// - Sits between the DDC channel outputs and the RX FIFO write port; detects and flags sample overrun.
// PARAMETERS
// - NCH_MAX  8   channel slots on d_in (fixed 8; d_in width = 16*NCH_MAX)
// - DW       16  sample word width
// PORTS
// - clk          in   1    system clock; all logic on rising edge
// - rst_n        in   1    synchronous reset, active low
// - enable       in   1    1 = accept strobes; 0 = ignore new strobes (an in-flight frame still completes)
// - numch        in   4    active channel count; sampled only at frame capture
// - strobe       in   1    1-cycle pulse: d_in holds a valid sample set
// - d_in         in   128  channel n in bits [16n+15:16n]
// - d_out        out  16   current output word
// - ch_onehot    out  8    one-hot tag of d_out's channel; 0 on header words
// - d_valid      out  1    d_out/ch_onehot/d_first/d_last valid
// - d_ready      in   1    downstream accepts; transfer = d_valid & d_ready
// - d_first      out  1    first word of frame
// - d_last       out  1    last word of frame
// - busy         out  1    frame in flight (state != IDLE)
// - overrun      out  1    sticky: a strobe was dropped
// - clr_overrun  in   1    clears overrun
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state=IDLE; d_out=0, ch_onehot=0, d_valid=0, d_first=0, d_last=0, busy=0, overrun=0.
//   Applies mid-frame too: the frame is abandoned and nothing further is emitted.
// - All outputs are registered.
// - nch = (numch==0) ? 0 : min(numch,8), computed at capture.
// - numch==0: strobes are ignored; no capture, no overrun.
// - FSM: IDLE -> (HDR, when CH_SEQ_HEADER_EN) -> SEND -> IDLE.
// - Capture: in IDLE, strobe & enable & nch!=0:
//   - latch d_in into snap[127:0] and nch into nch_l; idx=0.
//   - d_valid rises the next cycle (latency 1).
// - SEND:
//   - d_out=snap[16*idx+:16], ch_onehot=1<<idx, d_first=(idx==0 && no header), d_last=(idx==nch_l-1).
//   - On transfer: idx++. If idx was nch_l-1, the frame ends.
// - Stall: while d_valid & !d_ready, all outputs hold stable.
// - Frame end plus a capture-qualified strobe in the same cycle: capture the new frame immediately.
//   The next cycle shows the new frame's first word; no idle gap.
// - Strobe while busy, other than that same cycle: sample dropped, overrun<=1, current frame continues unchanged.
// - Dropped strobes while enable=1 and numch!=0 set overrun; strobes with enable=0 never do.
// - overrun set and clr_overrun in the same cycle: set wins.
// - Mid-frame changes to enable or numch have no effect until the next capture.
// - Throughput: 1 word/cycle with d_ready held high. Frame = nch words (+1 with header).
// CONFIGURATION
// - CH_SEQ_HEADER_EN defined:
//   - HDR state emits one word before channel 0: d_out={8'hA5, frame_cnt[7:0]}, ch_onehot=0, d_first=1, d_last=0.
//   - frame_cnt resets to 0, increments when the header word transfers, wraps 255->0.
// - CH_SEQ_HEADER_EN undefined: no HDR state, no frame_cnt; d_first marks channel 0.
// TESTING
// - numch=4, d_in words 0x1000..0x1007, d_ready=1, one strobe:
//   4 words 0x1000..0x1003 on consecutive cycles starting cycle+1; onehot 01,02,04,08; d_last on 0x1003.
// - numch=9, d_ready=1: 8 words 0x1000..0x1007 (clamped); numch=0 with strobe: d_valid never rises, overrun=0.
// - numch=2, d_ready low 3 cycles on word 0: d_out=0x1000 and ch_onehot=01 held stable; then 0x1001, no duplicates or drops.
// - numch=8, second strobe 3 cycles into frame: overrun=1, frame completes with original snapshot.
//   clr_overrun pulse then clears it. Strobe on the last-transfer cycle: back-to-back frame, overrun stays 0.
// - rst_n low mid-frame (idx=3): next cycle all outputs 0, state IDLE. Next strobe starts a fresh frame at ch0.
// - CH_SEQ_HEADER_EN, numch=1, three strobes:
//   pairs 0xA500/ch0, 0xA501/ch0, 0xA502/ch0, each header with d_first=1. Force 256 frames: counter wraps to 0xA500.

Source files
------------

// File: rtl/ch_frame_sequencer.sv
// Serialises a snapshot of 8 x 16-bit channels into a tagged valid/ready word stream.
// Optional CH_SEQ_HEADER_EN prepends a {8'hA5, frame_cnt} header word to every frame.
module ch_frame_sequencer #(
    parameter int NCH_MAX = 8,
    parameter int DW      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [3:0]            numch,
    input  logic                  strobe,
    input  logic [NCH_MAX*DW-1:0] d_in,
    output logic [DW-1:0]         d_out,
    output logic [NCH_MAX-1:0]    ch_onehot,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic                  d_first,
    output logic                  d_last,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    localparam int          IW       = $clog2(NCH_MAX);
    localparam logic [3:0]  NCH_MAX4 = 4'(NCH_MAX);
    localparam logic [NCH_MAX-1:0] OH0 = {{(NCH_MAX-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND
`ifdef CH_SEQ_HEADER_EN
        , S_HDR
`endif
    } state_t;

    state_t                state_q;
    logic [NCH_MAX*DW-1:0] snap_q;
    logic [3:0]            nch_l_q;
    logic [IW-1:0]         idx_q;
    logic [DW-1:0]         d_out_q;
    logic [NCH_MAX-1:0]    ch_onehot_q;
    logic                  d_valid_q, d_first_q, d_last_q, busy_q, overrun_q;
`ifdef CH_SEQ_HEADER_EN
    logic [7:0]            frame_cnt_q;
`endif

    logic [3:0]    nch_w;
    logic          cap_ok, xfer, last_xfer, start;
    logic [IW-1:0] idx_n;

    always_comb begin
        nch_w     = (numch > NCH_MAX4) ? NCH_MAX4 : numch;
        cap_ok    = strobe && enable && (nch_w != 4'd0);
        xfer      = d_valid_q && d_ready;
        last_xfer = (state_q == S_SEND) && xfer && (4'(idx_q) == nch_l_q - 4'd1);
        // A frame ending this cycle frees the sequencer for an immediate back-to-back capture.
        start     = cap_ok && ((state_q == S_IDLE) || last_xfer);
        idx_n     = idx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            snap_q      <= '0;
            nch_l_q     <= '0;
            idx_q       <= '0;
            d_out_q     <= '0;
            ch_onehot_q <= '0;
            d_valid_q   <= 1'b0;
            d_first_q   <= 1'b0;
            d_last_q    <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef CH_SEQ_HEADER_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            if (clr_overrun)
                overrun_q <= 1'b0;
            if (cap_ok && (state_q != S_IDLE) && !last_xfer)
                overrun_q <= 1'b1;

            if (start) begin
                snap_q    <= d_in;
                nch_l_q   <= nch_w;
                idx_q     <= '0;
                busy_q    <= 1'b1;
                d_valid_q <= 1'b1;
                d_first_q <= 1'b1;
`ifdef CH_SEQ_HEADER_EN
                state_q     <= S_HDR;
                d_out_q     <= {8'hA5, frame_cnt_q};
                ch_onehot_q <= '0;
                d_last_q    <= 1'b0;
`else
                state_q     <= S_SEND;
                d_out_q     <= d_in[DW-1:0];
                ch_onehot_q <= OH0;
                d_last_q    <= (nch_w == 4'd1);
`endif
            end else if (last_xfer) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                d_valid_q   <= 1'b0;
                d_first_q   <= 1'b0;
                d_last_q    <= 1'b0;
                d_out_q     <= '0;
                ch_onehot_q <= '0;
            end else if (xfer) begin
                case (state_q)
                    S_SEND: begin
                        idx_q       <= idx_n;
                        d_out_q     <= snap_q[DW*idx_n +: DW];
                        ch_onehot_q <= OH0 << idx_n;
                        d_first_q   <= 1'b0;
                        d_last_q    <= (4'(idx_n) == nch_l_q - 4'd1);
                    end
`ifdef CH_SEQ_HEADER_EN
                    S_HDR: begin
                        state_q     <= S_SEND;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        d_out_q     <= snap_q[DW-1:0];
                        ch_onehot_q <= OH0;
                        d_first_q   <= 1'b0;
                        d_last_q    <= (nch_l_q == 4'd1);
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign d_out     = d_out_q;
    assign ch_onehot = ch_onehot_q;
    assign d_valid   = d_valid_q;
    assign d_first   = d_first_q;
    assign d_last    = d_last_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_ch_frame_sequencer.sv
// Scoreboard bench for ch_frame_sequencer; header checks active when CH_SEQ_HEADER_EN is defined.
module tb_ch_frame_sequencer;

    logic         clk = 1'b0;
    logic         rst_n, enable, strobe, d_ready, clr_overrun;
    logic [3:0]   numch;
    logic [127:0] d_in;
    logic [15:0]  d_out;
    logic [7:0]   ch_onehot;
    logic         d_valid, d_first, d_last, busy, overrun;

    always #5 clk = ~clk;

`ifdef CH_SEQ_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    typedef struct packed {
        logic [15:0] d;
        logic [7:0]  oh;
        logic        f;
        logic        l;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_fc = 8'd0;

    ch_frame_sequencer #(.NCH_MAX(8), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .numch(numch), .strobe(strobe),
        .d_in(d_in), .d_out(d_out), .ch_onehot(ch_onehot), .d_valid(d_valid),
        .d_ready(d_ready), .d_first(d_first), .d_last(d_last), .busy(busy),
        .overrun(overrun), .clr_overrun(clr_overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && d_valid && d_ready) begin
            if (sb.size() == 0) begin
                fail_now("unexpected word");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("word d_out", {16'd0, d_out}, {16'd0, e.d});
                chk("word onehot", {24'd0, ch_onehot}, {24'd0, e.oh});
                chk("word first/last", {30'd0, d_first, d_last}, {30'd0, e.f, e.l});
            end
        end
    end

    task automatic set_din(input logic [15:0] base);
        for (int n = 0; n < 8; n++) d_in[16*n +: 16] = base + 16'(n);
    endtask

    task automatic push_frame(input int n, input logic [15:0] base);
        exp_t e;
        if (HDR != 0) begin
            e.d = {8'hA5, exp_fc}; e.oh = 8'h00; e.f = 1'b1; e.l = 1'b0;
            sb.push_back(e);
            exp_fc++;
        end
        for (int i = 0; i < n; i++) begin
            e.d  = base + 16'(i);
            e.oh = 8'(1 << i);
            e.f  = (i == 0) && (HDR == 0);
            e.l  = (i == n - 1);
            sb.push_back(e);
        end
    endtask

    // Called at posedge+1; leaves strobe high across exactly one posedge.
    task automatic do_strobe(input logic [3:0] nc, input bit expect_frame, input int n,
                             input logic [15:0] base);
        numch  = nc;
        strobe = 1'b1;
        if (expect_frame) push_frame(n, base);
        @(posedge clk); #1;
        strobe = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 500; i++) begin
            if (sb.size() == 0 && !busy) return;
            @(posedge clk); #1;
        end
        fail_now(name);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; strobe = 1'b0; d_ready = 1'b1; clr_overrun = 1'b0;
        numch = 4'd4; d_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {d_out, ch_onehot, 3'd0, d_valid, d_first, d_last, busy, overrun},
            32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic 4-channel frame with latency and back-to-back words.
        set_din(16'h1000);
        do_strobe(4'd4, 1'b1, 4, 16'h1000);
        for (int k = 0; k < 4 + HDR; k++) begin
            @(negedge clk);
            chk("numch4 valid run", {31'd0, d_valid}, 32'd1);
        end
        @(negedge clk);
        chk("numch4 valid drop", {31'd0, d_valid}, 32'd0);
        @(posedge clk); #1;
        wait_drain("drain numch4");

        // Clamp numch=9 to 8 channels.
        do_strobe(4'd9, 1'b1, 8, 16'h1000);
        wait_drain("drain numch9");

        // numch=0 strobe is ignored entirely.
        do_strobe(4'd0, 1'b0, 0, 16'h1000);
        repeat (5) begin
            @(negedge clk);
            chk("numch0 no valid", {31'd0, d_valid}, 32'd0);
        end
        chk("numch0 no overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk); #1;

        // Stall on the first word of a 2-channel frame.
        d_ready = 1'b0;
        do_strobe(4'd2, 1'b1, 2, 16'h1000);
        repeat (3) begin
            @(negedge clk);
            chk("stall d_out", {16'd0, d_out}, {16'd0, sb[0].d});
            chk("stall onehot", {24'd0, ch_onehot}, {24'd0, sb[0].oh});
            chk("stall valid", {31'd0, d_valid}, 32'd1);
        end
        @(posedge clk); #1;
        d_ready = 1'b1;
        wait_drain("drain stall");

        // Strobe mid-frame is dropped and flags overrun; frame keeps original snapshot.
        set_din(16'h1000);
        do_strobe(4'd8, 1'b1, 8, 16'h1000);
        repeat (2) @(posedge clk);
        #1;
        set_din(16'h2000);
        do_strobe(4'd8, 1'b0, 0, 16'h2000);
        @(negedge clk);
        chk("overrun set", {31'd0, overrun}, 32'd1);
        @(posedge clk); #1;
        wait_drain("drain overrun");
        chk("overrun sticky", {31'd0, overrun}, 32'd1);
        clr_overrun = 1'b1;
        @(posedge clk); #1;
        clr_overrun = 1'b0;
        chk("overrun cleared", {31'd0, overrun}, 32'd0);

        // Strobe on the last-transfer cycle starts the next frame with no gap.
        set_din(16'h1000);
        do_strobe(4'd2, 1'b1, 2, 16'h1000);
        begin
            bit found = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (d_valid && d_last) begin found = 1'b1; break; end
                @(posedge clk); #1;
            end
            if (!found) fail_now("wait last word");
        end
        set_din(16'h3000);
        do_strobe(4'd3, 1'b1, 3, 16'h3000);
        @(negedge clk);
        chk("b2b no gap", {31'd0, d_valid}, 32'd1);
        chk("b2b first", {31'd0, d_first}, 32'd1);
        @(posedge clk); #1;
        wait_drain("drain b2b");
        chk("b2b no overrun", {31'd0, overrun}, 32'd0);

        // Reset while channel 3 is on the bus.
        set_din(16'h1000);
        do_strobe(4'd8, 1'b1, 8, 16'h1000);
        begin
            bit found = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (d_valid && ch_onehot == 8'h08) begin found = 1'b1; break; end
                @(posedge clk); #1;
            end
            if (!found) fail_now("wait idx3");
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        exp_fc = 8'd0;
        rst_n  = 1'b1;
        chk("midreset outputs",
            {d_out, ch_onehot, 3'd0, d_valid, d_first, d_last, busy, overrun}, 32'd0);
        set_din(16'h4000);
        do_strobe(4'd3, 1'b1, 3, 16'h4000);
        wait_drain("drain after reset");

`ifdef CH_SEQ_HEADER_EN
        // Header counter sequence and wrap at 256 frames.
        set_din(16'h1000);
        for (int i = 0; i < 3; i++) begin
            do_strobe(4'd1, 1'b1, 1, 16'h1000);
            wait_drain("drain hdr");
        end
        while (exp_fc != 8'd0) begin
            do_strobe(4'd1, 1'b1, 1, 16'h1000);
            wait_drain("drain wrap");
        end
        do_strobe(4'd1, 1'b1, 1, 16'h1000);
        chk("wrap header", {16'd0, d_out}, 32'h0000A500);
        wait_drain("drain wrapped");
`endif

        chk("scoreboard empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
